// File: rtl/clock_monitor.sv
// clock_monitor: watches a slow clock from the main clock domain.
// Synchronizes clock_slow, emits a one-cycle tick per rising edge, measures
// the edge-to-edge period in main-clock cycles, range-checks it, and flags
// loss of the slow clock.
//
// Ports:
//   clock         main clock, all logic on its rising edge
//   reset_n       asynchronous active-low reset
//   clock_slow    monitored slow clock (asynchronous to clock)
//   clock_valid   PLL lock; monitoring runs only while high
//   tick          one-cycle pulse per synchronized rising edge of clock_slow
//   period        last measured period in clock cycles
//   period_valid  period holds a complete measurement
//   in_range      MIN_PERIOD <= period <= MAX_PERIOD (qualified by period_valid)
//   timeout       clock_slow is lost
//   edge_count    running tick count, wraps
module clock_monitor #(
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned MIN_PERIOD  = 12000,
    parameter int unsigned MAX_PERIOD  = 12600,
    parameter int unsigned TIMEOUT     = 16000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   clock_slow,
    input  logic                   clock_valid,
    output logic                   tick,
    output logic [COUNT_WIDTH-1:0] period,
    output logic                   period_valid,
    output logic                   in_range,
    output logic                   timeout,
    output logic [15:0]            edge_count
);

    localparam int unsigned EDGE_WIDTH = 16;

    localparam logic [COUNT_WIDTH-1:0] MIN_P   = COUNT_WIDTH'(MIN_PERIOD);
    localparam logic [COUNT_WIDTH-1:0] MAX_P   = COUNT_WIDTH'(MAX_PERIOD);
    localparam logic [COUNT_WIDTH-1:0] TO_LAST = COUNT_WIDTH'(TIMEOUT - 1);
    localparam logic [COUNT_WIDTH-1:0] ONE     = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        MEASURE = 2'd2,
        LOST    = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic                   s1, s2, s3;
    logic                   rise;
    logic [COUNT_WIDTH-1:0] cycle_count, count_next;
    logic                   tick_next;
    logic [COUNT_WIDTH-1:0] period_next;
    logic                   valid_next;
    logic                   range_next;
    logic                   timeout_next;
    logic [EDGE_WIDTH-1:0]  edges_next;

    assign rise = s2 & ~s3;

    // Next-state and output decode; losing clock_valid overrides everything.
    // The timeout compare uses the pre-increment count, and a rise in the
    // same cycle is handled first, so an edge landing exactly on TIMEOUT-1
    // is measured rather than declared lost.
    always_comb begin
        state_next   = state;
        count_next   = cycle_count;
        tick_next    = 1'b0;
        period_next  = period;
        valid_next   = period_valid;
        range_next   = in_range;
        timeout_next = timeout;
        edges_next   = edge_count;

        if (!clock_valid) begin
            state_next   = IDLE;
            count_next   = '0;
            valid_next   = 1'b0;
            range_next   = 1'b0;
            timeout_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = ACQUIRE;
                    count_next = '0;
                end
                ACQUIRE: begin
                    if (rise) begin
                        state_next = MEASURE;
                        tick_next  = 1'b1;
                        count_next = ONE;
                        edges_next = edge_count + EDGE_WIDTH'(1);
                    end else if (cycle_count == TO_LAST) begin
                        state_next   = LOST;
                        timeout_next = 1'b1;
                        valid_next   = 1'b0;
                        range_next   = 1'b0;
                    end else begin
                        count_next = cycle_count + ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        tick_next   = 1'b1;
                        period_next = cycle_count;
                        valid_next  = 1'b1;
                        range_next  = (cycle_count >= MIN_P) && (cycle_count <= MAX_P);
                        count_next  = ONE;
                        edges_next  = edge_count + EDGE_WIDTH'(1);
                    end else if (cycle_count == TO_LAST) begin
                        state_next   = LOST;
                        timeout_next = 1'b1;
                        valid_next   = 1'b0;
                        range_next   = 1'b0;
                    end else begin
                        count_next = cycle_count + ONE;
                    end
                end
                LOST: begin
                    // Count stays saturated; recovery restarts measurement
                    // but period_valid waits for the next full period.
                    if (rise) begin
                        state_next   = MEASURE;
                        tick_next    = 1'b1;
                        count_next   = ONE;
                        timeout_next = 1'b0;
                        edges_next   = edge_count + EDGE_WIDTH'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State, synchronizer and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            cycle_count  <= '0;
            tick         <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            in_range     <= 1'b0;
            timeout      <= 1'b0;
            edge_count   <= '0;
        end else begin
            state        <= state_next;
            s1           <= clock_slow;
            s2           <= s1;
            s3           <= s2;
            cycle_count  <= count_next;
            tick         <= tick_next;
            period       <= period_next;
            period_valid <= valid_next;
            in_range     <= range_next;
            timeout      <= timeout_next;
            edge_count   <= edges_next;
        end
    end

endmodule

// File: tb/tb_clock_monitor.sv
// Testbench for clock_monitor. Uses smaller windows than the defaults
// (MIN 120, MAX 126, TIMEOUT 160); all expectations are written for these.
module tb_clock_monitor;

    localparam int unsigned CW   = 16;
    localparam int unsigned MINP = 120;
    localparam int unsigned MAXP = 126;
    localparam int unsigned TO   = 160;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          clock_slow;
    logic          clock_valid;
    logic          tick;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          in_range;
    logic          timeout;
    logic [15:0]   edge_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_edges = 16'd0;

    clock_monitor #(
        .COUNT_WIDTH(CW),
        .MIN_PERIOD (MINP),
        .MAX_PERIOD (MAXP),
        .TIMEOUT    (TO)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .clock_slow  (clock_slow),
        .clock_valid (clock_valid),
        .tick        (tick),
        .period      (period),
        .period_valid(period_valid),
        .in_range    (in_range),
        .timeout     (timeout),
        .edge_count  (edge_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          p;          // cycles until the next rising edge
        logic        exp_valid;  // expected at this edge's tick
        logic [15:0] exp_period;
        logic        exp_range;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One rising edge of clock_slow followed by an interval of p cycles.
    // Checks tick latency (3 cycles), width, and the outputs at the tick.
    task automatic slow_edge(input int p, input logic exp_valid, input logic [15:0] exp_period,
                             input logic exp_range, input logic exp_timeout, input string name);
        clock_slow = 1'b1;
        repeat (2) @(negedge clock);
        chk({name, ".tick_early"}, 32'(tick), 32'd0);
        @(negedge clock);
        exp_edges = exp_edges + 16'd1;
        chk({name, ".tick"}, 32'(tick), 32'd1);
        chk({name, ".period_valid"}, 32'(period_valid), 32'(exp_valid));
        chk({name, ".period"}, 32'(period), 32'(exp_period));
        chk({name, ".in_range"}, 32'(in_range), 32'(exp_range));
        chk({name, ".timeout"}, 32'(timeout), 32'(exp_timeout));
        chk({name, ".edge_count"}, 32'(edge_count), 32'(exp_edges));
        @(negedge clock);
        chk({name, ".tick_width"}, 32'(tick), 32'd0);
        repeat (p / 2 - 4) @(negedge clock);
        clock_slow = 1'b0;
        repeat (p - p / 2) @(negedge clock);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".tick"}, 32'(tick), 32'd0);
        chk({name, ".period"}, 32'(period), 32'd0);
        chk({name, ".period_valid"}, 32'(period_valid), 32'd0);
        chk({name, ".in_range"}, 32'(in_range), 32'd0);
        chk({name, ".timeout"}, 32'(timeout), 32'd0);
        chk({name, ".edge_count"}, 32'(edge_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;

        // Each entry's edge measures the previous entry's interval.
        vecs[0] = '{123, 1'b0, 16'd0,   1'b0};
        vecs[1] = '{123, 1'b1, 16'd123, 1'b1};
        vecs[2] = '{100, 1'b1, 16'd123, 1'b1};
        vecs[3] = '{126, 1'b1, 16'd100, 1'b0};
        vecs[4] = '{127, 1'b1, 16'd126, 1'b1};
        vecs[5] = '{120, 1'b1, 16'd127, 1'b0};
        vecs[6] = '{119, 1'b1, 16'd120, 1'b1};
        vecs[7] = '{123, 1'b1, 16'd119, 1'b0};

        // Reset with the slow clock toggling.
        reset_n     = 1'b0;
        clock_valid = 1'b0;
        clock_slow  = 1'b0;
        repeat (4) begin
            @(negedge clock);
            clock_slow = ~clock_slow;
        end
        chk_all_zero("reset");

        // Out of reset, no PLL lock: nothing may happen.
        reset_n = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            if (tick || period_valid || in_range || timeout || (edge_count != 16'd0))
                seen = 1'b1;
            if (i % 3 == 0) clock_slow = ~clock_slow;
        end
        clock_slow = 1'b0;
        repeat (4) @(negedge clock);
        chk("no_pll.activity", 32'(seen), 32'd0);
        chk_all_zero("no_pll");

        // Lock, then nominal and range-boundary periods.
        clock_valid = 1'b1;
        repeat (5) @(negedge clock);
        for (int i = 0; i < 8; i++)
            slow_edge(vecs[i].p, vecs[i].exp_valid, vecs[i].exp_period,
                      vecs[i].exp_range, 1'b0, $sformatf("vec%0d", i));

        // Last edge, then the slow clock stops (held high).
        clock_slow = 1'b1;
        repeat (3) @(negedge clock);
        exp_edges = exp_edges + 16'd1;
        chk("stop.tick", 32'(tick), 32'd1);
        chk("stop.period", 32'(period), 32'd123);
        chk("stop.in_range", 32'(in_range), 32'd1);
        repeat (TO - 2) @(negedge clock);
        chk("loss.timeout_before", 32'(timeout), 32'd0);
        chk("loss.valid_before", 32'(period_valid), 32'd1);
        @(negedge clock);
        chk("loss.timeout", 32'(timeout), 32'd1);
        chk("loss.period_valid", 32'(period_valid), 32'd0);
        chk("loss.in_range", 32'(in_range), 32'd0);
        chk("loss.period_held", 32'(period), 32'd123);
        repeat (40) @(negedge clock);
        chk("loss.timeout_held", 32'(timeout), 32'd1);
        chk("loss.edge_count", 32'(edge_count), 32'(exp_edges));
        clock_slow = 1'b0;
        repeat (5) @(negedge clock);

        // Recovery: timeout clears at the first tick, period at the second.
        slow_edge(124, 1'b0, 16'd123, 1'b0, 1'b0, "restart1");
        slow_edge(122, 1'b1, 16'd124, 1'b1, 1'b0, "restart2");
        slow_edge(20,  1'b1, 16'd122, 1'b1, 1'b0, "pre_drop");

        // PLL drop mid-period, with a slow edge while unlocked.
        clock_valid = 1'b0;
        @(negedge clock);
        chk("drop.period_valid", 32'(period_valid), 32'd0);
        chk("drop.in_range", 32'(in_range), 32'd0);
        chk("drop.timeout", 32'(timeout), 32'd0);
        chk("drop.period_held", 32'(period), 32'd122);
        seen       = 1'b0;
        clock_slow = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (tick) seen = 1'b1;
            if (i == 5) clock_slow = 1'b0;
        end
        chk("drop.no_tick", 32'(seen), 32'd0);
        chk("drop.edge_count", 32'(edge_count), 32'(exp_edges));
        clock_valid = 1'b1;
        repeat (3) @(negedge clock);
        chk("relock.period_valid", 32'(period_valid), 32'd0);
        chk("relock.period_held", 32'(period), 32'd122);
        slow_edge(124, 1'b0, 16'd122, 1'b0, 1'b0, "reacq1");
        slow_edge(159, 1'b1, 16'd124, 1'b1, 1'b0, "reacq2");

        // Edge on the cycle the count reaches TIMEOUT-1: measured, no timeout.
        slow_edge(20, 1'b1, 16'd159, 1'b0, 1'b0, "tie");

        // edge_count wrap; the forced cycle lengthens the interval to 21.
        force dut.edge_count = 16'hFFFF;
        @(negedge clock);
        release dut.edge_count;
        exp_edges = 16'hFFFF;
        slow_edge(30, 1'b1, 16'd21, 1'b0, 1'b0, "wrap");
        slow_edge(10, 1'b1, 16'd30, 1'b0, 1'b0, "post_wrap");

        // Asynchronous reset mid-measurement clears everything immediately.
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("async_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
